decoder: RTL and testbench
==========================

// Module: decoder
// PURPOSE
//  Inverse of the tokenizer encoder. Reads a code stream from a code RAM, then expands each code into
//  its vocabulary string, and writes the concatenated text to an output RAM.
//  Code c selects the c-th (0-based) zero-terminated entry in the vocab RAM. Sits beside encoder on the
//  same synchronous-read sram instances; the top level owns the RAMs and wires them to this block.
// PARAMETERS
//  ADDR_WIDTH  4      address width of code, vocab and output RAMs
//  DATA_WIDTH  8      width of one character / one code
//  END_CODE    '1     code value that terminates the code stream (never a vocab index)
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           asynchronous active-low reset
//  cs          in   1           start; sampled only in IDLE
//  code_addr   out  ADDR_WIDTH  code RAM read address (registered)
//  code_dout   in   DATA_WIDTH  code RAM read data, valid 1 cycle after address
//  vocab_addr  out  ADDR_WIDTH  vocab RAM read address (registered)
//  vocab_dout  in   DATA_WIDTH  vocab RAM read data, valid 1 cycle after address
//  out_we      out  1           output RAM write enable
//  out_addr    out  ADDR_WIDTH  output RAM write address (registered)
//  out_din     out  DATA_WIDTH  output RAM write data
//  done        out  1           sticky completion flag
//  err         out  1           sticky error flag (done also set)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all address registers 0, skip_cnt=0, done=0, err=0, out_we=0.
//  Every RAM read is 2 cycles: *_REQ holds address over one edge, *_EVAL consumes dout.
//  FSM states:
//   IDLE:   cs=1 -> code_addr<=0, out_addr<=0, C_REQ. cs=0 -> stay.
//   C_REQ:  -> C_EVAL.
//   C_EVAL: code_dout==END_CODE -> TERM. Else: skip_cnt<=code_dout, vocab_addr<=0 -> V_REQ.
//   V_REQ:  -> V_EVAL.
//   V_EVAL, skip_cnt!=0 (seeking):
//    vocab_dout==0 -> skip_cnt--.
//    vocab_addr==max -> ERR. Else vocab_addr++ -> V_REQ.
//   V_EVAL, skip_cnt==0 (copying):
//    vocab_dout==0 -> entry done. code_addr==max -> ERR. Else code_addr++ -> C_REQ.
//    vocab_dout!=0 -> out_we=1, out_din=vocab_dout at out_addr (combinational this cycle).
//     out_addr==max -> no write, ERR (terminator slot required).
//     vocab_addr==max -> write, then ERR.
//     Otherwise out_addr++, vocab_addr++ -> V_REQ.
//   TERM:   out_we=1, out_din=0 at out_addr; -> DONE.
//   DONE:   done=1, hold until reset; cs ignored.
//   ERR:    err=1, done=1, no further writes, hold until reset.
//  out_we is high only in V_EVAL-copy and TERM, one cycle per character.
//  cs while not IDLE is ignored.
//  Empty vocab entry (leading 0) emits nothing.
//  Empty code stream (first code END_CODE) writes a single 0 at out_addr 0.
//  All address counters are ADDR_WIDTH wide; wrap is never taken, the max checks above go to ERR instead.
//  code_dout is compared with === semantics against END_CODE; X on code_dout is a bench error.
// STRUCTURE
//  tokenizer_pkg: typedef enum decoder_state {IDLE,C_REQ,C_EVAL,V_REQ,V_EVAL,TERM,DONE,ERR}; END_CODE default.
//  Single module. The seek/copy datapath (vocab_addr, skip_cnt) may be split into sub-module vocab_walker.
//  Bench wraps with three sram instances (INIT_FILE for code and vocab).
// TESTING
//  vocab=61 62 00 63 00 64 65 00, codes=02 00 FF, pulse cs -> out=64 65 61 62 00 at 0..4, done=1, err=0.
//  Same vocab, codes=FF -> single write 00 at addr 0, done=1, out_we high exactly 1 cycle.
//  codes=01 01 FF -> out=63 63 00; out_we pulses exactly 3 times.
//  ADDR_WIDTH=4, codes=00 x8 FF (16 chars needed) -> 15 chars written, then err=1, done=1, no terminator.
//  codes=07 FF with only 3 vocab entries -> vocab_addr reaches 15, err=1, done=1, no out_we.
//  Assert rst_n low mid-V_EVAL copy -> done=0, err=0, out_we=0 immediately. Restart with cs -> correct output.

Source files
------------

// File: rtl/tokenizer_pkg.sv
// ---------------------------------------------------------------------------
// tokenizer_pkg
// Shared definitions for the tokenizer blocks (encoder / decoder).
//  - decoder_state : state encoding of the decoder FSM
//  - DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default RAM geometry
// ---------------------------------------------------------------------------
package tokenizer_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        C_REQ  = 3'd1,
        C_EVAL = 3'd2,
        V_REQ  = 3'd3,
        V_EVAL = 3'd4,
        TERM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } decoder_state;

endpackage

// File: rtl/decoder_vocab_walker.sv
// ---------------------------------------------------------------------------
// vocab_walker
// Seek/copy datapath of the decoder: the vocab RAM read address and the
// count of zero terminators still to be skipped before the wanted entry.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  i_load         start a new entry: skip_cnt <= i_load_val, address <= 0
//  i_load_val     code value (index of the vocab entry)
//  i_dec          one terminator passed while seeking
//  i_adv          step to the next vocab character
//  o_vocab_addr   registered vocab RAM address
//  o_seeking      skip_cnt is non-zero (still looking for the entry)
//  o_at_max       address sits on the last RAM location
// ---------------------------------------------------------------------------
module vocab_walker
    import tokenizer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_val,
    input  logic                  i_dec,
    input  logic                  i_adv,
    output logic [ADDR_WIDTH-1:0] o_vocab_addr,
    output logic                  o_seeking,
    output logic                  o_at_max
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] SKIP_ONE = DATA_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_vocab_addr;
    logic [DATA_WIDTH-1:0] r_skip_cnt;

    // A load restarts the walk at the top of the vocab RAM; the FSM never
    // asks for load together with dec/adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vocab_addr <= '0;
            r_skip_cnt   <= '0;
        end else if (i_load) begin
            r_vocab_addr <= '0;
            r_skip_cnt   <= i_load_val;
        end else begin
            if (i_dec) begin
                r_skip_cnt <= r_skip_cnt - SKIP_ONE;
            end
            if (i_adv) begin
                r_vocab_addr <= r_vocab_addr + ADDR_ONE;
            end
        end
    end

    assign o_vocab_addr = r_vocab_addr;
    assign o_seeking    = (r_skip_cnt != '0);
    assign o_at_max     = &r_vocab_addr;

endmodule

// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
// Expands a stream of vocabulary codes back into text. Each code c selects
// the c-th zero-terminated string of the vocab RAM; the strings are written
// back-to-back into the output RAM followed by a single 0 terminator.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  cs           start request, only looked at in IDLE
//  code_addr    code RAM read address      / code_dout  read data (+1 cycle)
//  vocab_addr   vocab RAM read address     / vocab_dout read data (+1 cycle)
//  out_we       output RAM write enable, out_addr / out_din write port
//  done         sticky completion flag (also set on error)
//  err          sticky error flag
// ---------------------------------------------------------------------------
module decoder
    import tokenizer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] END_CODE   = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic [ADDR_WIDTH-1:0] code_addr,
    input  logic [DATA_WIDTH-1:0] code_dout,
    output logic [ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0] vocab_dout,
    output logic                  out_we,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    decoder_state r_state;
    decoder_state w_next;

    logic [ADDR_WIDTH-1:0] r_code_addr;
    logic [ADDR_WIDTH-1:0] r_out_addr;

    logic w_code_clr;
    logic w_code_inc;
    logic w_out_clr;
    logic w_out_inc;
    logic w_load;
    logic w_dec;
    logic w_adv;
    logic w_seeking;
    logic w_vocab_max;
    logic w_code_max;
    logic w_out_max;

    assign w_code_max = &r_code_addr;
    assign w_out_max  = &r_out_addr;

    vocab_walker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_walker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_val   (code_dout),
        .i_dec        (w_dec),
        .i_adv        (w_adv),
        .o_vocab_addr (vocab_addr),
        .o_seeking    (w_seeking),
        .o_at_max     (w_vocab_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_addr <= '0;
            r_out_addr  <= '0;
        end else begin
            if (w_code_clr) begin
                r_code_addr <= '0;
            end else if (w_code_inc) begin
                r_code_addr <= r_code_addr + ADDR_ONE;
            end
            if (w_out_clr) begin
                r_out_addr <= '0;
            end else if (w_out_inc) begin
                r_out_addr <= r_out_addr + ADDR_ONE;
            end
        end
    end

    // Address counters never wrap: reaching the last location where another
    // step would be needed sends the FSM to ERR instead. A character landing
    // on the last output slot is refused because the terminator must fit.
    always_comb begin
        w_next     = r_state;
        out_we     = 1'b0;
        out_din    = '0;
        w_code_clr = 1'b0;
        w_code_inc = 1'b0;
        w_out_clr  = 1'b0;
        w_out_inc  = 1'b0;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_adv      = 1'b0;
        case (r_state)
            IDLE: begin
                if (cs) begin
                    w_code_clr = 1'b1;
                    w_out_clr  = 1'b1;
                    w_next     = C_REQ;
                end
            end
            C_REQ: begin
                w_next = C_EVAL;
            end
            C_EVAL: begin
                if (code_dout == END_CODE) begin
                    w_next = TERM;
                end else begin
                    w_load = 1'b1;
                    w_next = V_REQ;
                end
            end
            V_REQ: begin
                w_next = V_EVAL;
            end
            V_EVAL: begin
                if (w_seeking) begin
                    if (vocab_dout == '0) begin
                        w_dec = 1'b1;
                    end
                    if (w_vocab_max) begin
                        w_next = ERR;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = V_REQ;
                    end
                end else if (vocab_dout == '0) begin
                    if (w_code_max) begin
                        w_next = ERR;
                    end else begin
                        w_code_inc = 1'b1;
                        w_next     = C_REQ;
                    end
                end else if (w_out_max) begin
                    w_next = ERR;
                end else begin
                    out_we  = 1'b1;
                    out_din = vocab_dout;
                    if (w_vocab_max) begin
                        w_next = ERR;
                    end else begin
                        w_out_inc = 1'b1;
                        w_adv     = 1'b1;
                        w_next    = V_REQ;
                    end
                end
            end
            TERM: begin
                out_we = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                w_next = DONE;
            end
            ERR: begin
                w_next = ERR;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign code_addr = r_code_addr;
    assign out_addr  = r_out_addr;
    assign done      = (r_state == DONE) || (r_state == ERR);
    assign err       = (r_state == ERR);

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
// Wraps the decoder with behavioural code/vocab/output RAMs (synchronous
// read, one cycle latency) and runs a table of directed decode jobs plus a
// reset-during-copy sequence.
// ---------------------------------------------------------------------------
module tb_decoder;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MAX_CYCLES = 600;
    localparam int NUM_VEC = 5;

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic [AW-1:0] code_addr;
    logic [DW-1:0] code_dout;
    logic [AW-1:0] vocab_addr;
    logic [DW-1:0] vocab_dout;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_din;
    logic          done;
    logic          err;

    logic [DW-1:0] codeMem  [16];
    logic [DW-1:0] vocabMem [16];
    logic [DW-1:0] outMem   [16];

    int testsRun;
    int testsFailed;
    int weCount;

    // Memory images are written in reading order: byte 0 is the leftmost
    // pair of hex digits of the 128-bit value.
    typedef struct {
        string        name;
        logic [127:0] codes;
        logic [127:0] vocab;
        logic [127:0] expOut;
        int           expWe;
        logic         expDone;
        logic         expErr;
        int           expVaddr;
    } vec_t;

    vec_t vecs [NUM_VEC];

    decoder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .END_CODE   (8'hFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .code_addr  (code_addr),
        .code_dout  (code_dout),
        .vocab_addr (vocab_addr),
        .vocab_dout (vocab_dout),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .out_din    (out_din),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM models and the output RAM write port.
    always @(posedge clk) begin
        code_dout  <= codeMem[code_addr];
        vocab_dout <= vocabMem[vocab_addr];
        if (out_we) begin
            outMem[out_addr] <= out_din;
        end
    end

    // Write strobes are counted away from the active edge.
    always @(negedge clk) begin
        if (out_we) begin
            weCount = weCount + 1;
        end
    end

    function automatic logic [7:0] getByte(input logic [127:0] img, input int i);
        return img[127 - 8*i -: 8];
    endfunction

    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (actual !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, actual, expected);
        end
    endtask

    task automatic loadImages(input int idx);
        for (int i = 0; i < 16; i++) begin
            codeMem[i]  = getByte(vecs[idx].codes, i);
            vocabMem[i] = getByte(vecs[idx].vocab, i);
            outMem[i]   = 8'hEE;
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        cs    = 1'b0;
        repeat (2) @(negedge clk);
        weCount = 0;
        rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic waitDone(input string what);
        int n;
        n = 0;
        while (done !== 1'b1 && n < MAX_CYCLES) begin
            @(negedge clk);
            n++;
        end
        checkOutput({what, " finished in budget"}, 32'(done === 1'b1), 32'd1);
        // a few extra cycles show that nothing else is written afterwards
        repeat (4) @(negedge clk);
    endtask

    task automatic checkResult(input int idx);
        string nm;
        nm = vecs[idx].name;
        checkOutput({nm, " done"}, 32'(done), 32'(vecs[idx].expDone));
        checkOutput({nm, " err"}, 32'(err), 32'(vecs[idx].expErr));
        checkOutput({nm, " out_we count"}, 32'(weCount), 32'(vecs[idx].expWe));
        checkOutput({nm, " vocab_addr"}, 32'(vocab_addr), 32'(vecs[idx].expVaddr));
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("%s out[%0d]", nm, i), 32'(outMem[i]),
                        32'(getByte(vecs[idx].expOut, i)));
        end
    endtask

    task automatic applyStimulus(input int idx);
        loadImages(idx);
        resetDut();
        pulseStart();
        waitDone(vecs[idx].name);
        checkResult(idx);
    endtask

    initial begin
        int n;
        testsRun    = 0;
        testsFailed = 0;
        weCount     = 0;
        rst_n       = 1'b1;
        cs          = 1'b0;

        vecs[0] = '{"two_codes", 128'h0200FF00_00000000_00000000_00000000,
                    128'h61620063_00646500_00000000_00000000,
                    128'h64656162_00EEEEEE_EEEEEEEE_EEEEEEEE, 5, 1'b1, 1'b0, 2};
        vecs[1] = '{"empty_stream", 128'hFF000000_00000000_00000000_00000000,
                    128'h61620063_00646500_00000000_00000000,
                    128'h00EEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 1, 1'b1, 1'b0, 0};
        vecs[2] = '{"repeat_code", 128'h0101FF00_00000000_00000000_00000000,
                    128'h61620063_00646500_00000000_00000000,
                    128'h636300EE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 3, 1'b1, 1'b0, 4};
        vecs[3] = '{"out_overflow", 128'h00000000_00000000_FF000000_00000000,
                    128'h61620063_00646500_00000000_00000000,
                    128'h61626162_61626162_61626162_616261EE, 15, 1'b1, 1'b1, 1};
        vecs[4] = '{"vocab_overrun", 128'h07FF0000_00000000_00000000_00000000,
                    128'h61620063_00646500_78787878_78787878,
                    128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE, 0, 1'b1, 1'b1, 15};

        // reset state
        loadImages(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset out_we", 32'(out_we), 32'd0);
        checkOutput("reset code_addr", 32'(code_addr), 32'd0);
        checkOutput("reset vocab_addr", 32'(vocab_addr), 32'd0);
        checkOutput("reset out_addr", 32'(out_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // idle without cs stays put
        repeat (5) @(negedge clk);
        checkOutput("idle no start done", 32'(done), 32'd0);
        checkOutput("idle no start writes", 32'(weCount), 32'd0);

        for (int v = 0; v < NUM_VEC; v++) begin
            applyStimulus(v);
        end

        // cs after completion is ignored: nothing more is written
        pulseStart();
        repeat (10) @(negedge clk);
        checkOutput("cs in ERR ignored writes", 32'(weCount), 32'd0);
        checkOutput("cs in ERR keeps err", 32'(err), 32'd1);

        // reset asserted while a character is being copied
        loadImages(0);
        resetDut();
        pulseStart();
        n = 0;
        while (out_we !== 1'b1 && n < MAX_CYCLES) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midcopy reached copy", 32'(out_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midcopy reset out_we", 32'(out_we), 32'd0);
        checkOutput("midcopy reset done", 32'(done), 32'd0);
        checkOutput("midcopy reset err", 32'(err), 32'd0);
        checkOutput("midcopy reset vocab_addr", 32'(vocab_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            outMem[i] = 8'hEE;
        end
        weCount = 0;
        pulseStart();
        waitDone("restart");
        checkResult(0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
